// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with a multi-cycle word RAM, sub-word load extraction
// and registered MEM/WB outputs; stall holds upstream while an access is in flight.
module mem_stage #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic [1:0]  load_mode_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  writebackDestination_in,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] memData_out,
  output logic [31:0] aluResult_out,
  output logic [4:0]  writebackDestination_out,
  output logic        misaligned_out
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic [1:0] off;
  logic access, mis, done, is_load;
  logic [31:0] w, ld;
  logic [15:0] h;
  logic [7:0] b;
  assign idx = aluResult_in[ADDR_BITS+1:2];
  assign off = aluResult_in[1:0];
  assign access = MemRead_in | MemWrite_in;
  assign done = ~stall;
  // stores are always word-sized, so any store with a nonzero offset faults
  assign mis = access & ((MemWrite_in | load_mode_in == 2'd0) ? off != 2'd0
                                                              : (load_mode_in == 2'd1 & off[0]));
  assign is_load = MemRead_in & ~MemWrite_in & ~mis;
  assign w = ram[idx];
  assign b = w[{off, 3'b000} +: 8];
  assign h = off[1] ? w[31:16] : w[15:0];
  assign ld = load_mode_in == 2'd0 ? w :
              load_mode_in == 2'd1 ? {{16{h[15]}}, h} :
              load_mode_in == 2'd2 ? {{24{b[7]}}, b} : {24'b0, b};
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    stall = 1'b0;
    if (state == IDLE) begin
      stall = rst_n && access && (LATENCY > 1);
      if (stall) begin
        state_nx = BUSY;
        cnt_nx = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
      end
    end else begin
      stall = rst_n && cnt != '0;
      cnt_nx = stall ? cnt - CW'(1) : cnt;
      state_nx = stall ? BUSY : IDLE;
    end
  end
  // gated by rst_n so a store caught by reset is never committed
  always_ff @(posedge clk)
    if (rst_n && done && MemWrite_in && !mis) ram[idx] <= rt_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      RegWrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
      memData_out <= '0;
      aluResult_out <= '0;
      writebackDestination_out <= '0;
      misaligned_out <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      RegWrite_out <= done & RegWrite_in & ~mis;
      MemToReg_out <= done & MemToReg_in;
      memData_out <= (done & is_load) ? ld : '0;
      aluResult_out <= done ? aluResult_in : '0;
      writebackDestination_out <= done ? writebackDestination_in : '0;
      misaligned_out <= done & mis;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: checks a LATENCY=1 and a LATENCY=3 mem_stage against directed vectors
// and an array-based memory model under random load/store traffic.
module tb_mem_stage;
  typedef struct packed {
    logic rw, mw, mr, mtr;
    logic [1:0] mode;
    logic [31:0] alu, rt;
    logic [4:0] dest;
  } in_t;
  typedef struct packed {
    logic rw, mtr;
    logic [31:0] data, alu;
    logic [4:0] dest;
    logic mis;
  } out_t;
  typedef struct {
    in_t x;
    logic rw, mtr, mis;
    logic [31:0] data;
    logic [4:0] dest;
  } vec_t;

  logic clk = 0, rst_n = 0;
  in_t i1, i3;
  out_t o1, o3;
  logic st1, st3;
  int checks = 0, errs = 0;
  logic [31:0] mem [2][256];
  vec_t tbl[16];

  always #5 clk = ~clk;

  mem_stage #(.ADDR_BITS(8), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .RegWrite_in(i1.rw), .MemWrite_in(i1.mw), .MemRead_in(i1.mr),
    .MemToReg_in(i1.mtr), .load_mode_in(i1.mode), .aluResult_in(i1.alu), .rt_in(i1.rt),
    .writebackDestination_in(i1.dest), .stall(st1), .RegWrite_out(o1.rw),
    .MemToReg_out(o1.mtr), .memData_out(o1.data), .aluResult_out(o1.alu),
    .writebackDestination_out(o1.dest), .misaligned_out(o1.mis));

  mem_stage #(.ADDR_BITS(8), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .RegWrite_in(i3.rw), .MemWrite_in(i3.mw), .MemRead_in(i3.mr),
    .MemToReg_in(i3.mtr), .load_mode_in(i3.mode), .aluResult_in(i3.alu), .rt_in(i3.rt),
    .writebackDestination_in(i3.dest), .stall(st3), .RegWrite_out(o3.rw),
    .MemToReg_out(o3.mtr), .memData_out(o3.data), .aluResult_out(o3.alu),
    .writebackDestination_out(o3.dest), .misaligned_out(o3.mis));

  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic in_t mkin(logic rw, mw, mr, mtr, logic [1:0] mode,
                               logic [31:0] alu, rt, logic [4:0] dest);
    in_t x;
    x.rw = rw; x.mw = mw; x.mr = mr; x.mtr = mtr; x.mode = mode;
    x.alu = alu; x.rt = rt; x.dest = dest;
    return x;
  endfunction

  // Reference: reads/writes a plain word array; sub-word data via shifts and sign arithmetic.
  function automatic out_t model(int d, in_t x);
    out_t o;
    int m = (d == 1) ? 0 : 1;
    int ix = int'(x.alu[9:2]);
    int ofs = int'(x.alu[1:0]);
    bit acc = x.mr || x.mw;
    bit bad;
    logic [31:0] wd = mem[m][ix];
    int v;
    if (x.mw || x.mode == 0) bad = acc && ofs != 0;
    else bad = acc && x.mode == 1 && (ofs % 2) == 1;
    case (x.mode)
      2'd0: v = int'(wd);
      2'd1: begin v = int'((wd >> (16 * (ofs / 2))) & 32'hFFFF); if (v >= 32768) v -= 65536; end
      2'd2: begin v = int'((wd >> (8 * ofs)) & 32'hFF); if (v >= 128) v -= 256; end
      default: v = int'((wd >> (8 * ofs)) & 32'hFF);
    endcase
    o.rw = x.rw && !bad;
    o.mtr = x.mtr;
    o.data = (x.mr && !x.mw && !bad) ? 32'(v) : 32'h0;
    o.alu = x.alu;
    o.dest = x.dest;
    o.mis = bad;
    if (x.mw && !bad) mem[m][ix] = x.rt;
    return o;
  endfunction

  // Caller sits at a negedge; returns at the negedge after the completion edge.
  task automatic issue(input int d, input in_t x, input out_t e);
    int lat = (d == 3 && (x.mr || x.mw)) ? 3 : 1;
    if (d == 1) i1 = x; else i3 = x;
    for (int k = 0; k < lat; k++) begin
      #1 chk("stall", (d == 1) ? st1 : st3, k < lat - 1);
      @(posedge clk);
      #1;
      if (k < lat - 1) chk("bubble", (d == 1) ? o1 : o3, '0);
      @(negedge clk);
    end
    chk("result", (d == 1) ? o1 : o3, e);
    if (d == 1) i1 = '0; else i3 = '0;
  endtask

  initial begin
    out_t e;
    in_t x;
    i1 = '0;
    i3 = '0;
    tbl[0]  = '{mkin(0,1,0,0,0,32'h10,32'hDEADBEEF,0), 0,0,0,32'h0,0};
    tbl[1]  = '{mkin(1,0,1,1,0,32'h10,32'h0,5), 1,1,0,32'hDEADBEEF,5};
    tbl[2]  = '{mkin(0,1,0,0,0,32'h20,32'h80F17F82,0), 0,0,0,32'h0,0};
    tbl[3]  = '{mkin(1,0,1,1,2,32'h20,32'h0,1), 1,1,0,32'hFFFFFF82,1};
    tbl[4]  = '{mkin(1,0,1,1,3,32'h20,32'h0,1), 1,1,0,32'h00000082,1};
    tbl[5]  = '{mkin(1,0,1,1,2,32'h21,32'h0,1), 1,1,0,32'h0000007F,1};
    tbl[6]  = '{mkin(1,0,1,1,1,32'h22,32'h0,1), 1,1,0,32'hFFFF80F1,1};
    tbl[7]  = '{mkin(1,0,0,0,0,32'h12345,32'h0,7), 1,0,0,32'h0,7};
    tbl[8]  = '{mkin(0,1,0,0,0,32'h30,32'hCAFEF00D,0), 0,0,0,32'h0,0};
    tbl[9]  = '{mkin(0,1,0,0,0,32'h31,32'h12345678,0), 0,0,1,32'h0,0};
    tbl[10] = '{mkin(1,0,1,1,0,32'h30,32'h0,3), 1,1,0,32'hCAFEF00D,3};
    tbl[11] = '{mkin(1,0,1,1,1,32'h23,32'h0,2), 0,1,1,32'h0,2};
    tbl[12] = '{mkin(0,1,0,0,0,32'h40,32'h11112222,0), 0,0,0,32'h0,0};
    tbl[13] = '{mkin(1,1,1,0,0,32'h50,32'hA5A5A5A5,4), 1,0,0,32'h0,4};
    tbl[14] = '{mkin(1,0,1,1,0,32'h50,32'h0,6), 1,1,0,32'hA5A5A5A5,6};
    tbl[15] = '{mkin(1,0,1,1,0,32'hFFFFFC10,32'h0,9), 1,1,0,32'hDEADBEEF,9};

    #12;
    chk("reset_o1", o1, '0);
    chk("reset_o3", o3, '0);
    chk("reset_st1", st1, 0);
    chk("reset_st3", st3, 0);
    @(negedge clk);
    rst_n = 1;

    for (int d = 1; d <= 3; d += 2)
      for (int i = 0; i < 16; i++) begin
        x = mkin(0, 1, 0, 0, 0, 32'(i * 4), $urandom(), 0);
        e = model(d, x);
        issue(d, x, e);
      end

    for (int d = 1; d <= 3; d += 2)
      foreach (tbl[i]) begin
        void'(model(d, tbl[i].x));
        e.rw = tbl[i].rw; e.mtr = tbl[i].mtr; e.data = tbl[i].data;
        e.alu = tbl[i].x.alu; e.dest = tbl[i].dest; e.mis = tbl[i].mis;
        issue(d, tbl[i].x, e);
      end

    i3 = mkin(0, 1, 0, 0, 0, 32'h40, 32'h33334444, 0);
    #1 chk("abort_stall_pre", st3, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_stall", st3, 0);
    chk("abort_o3", o3, '0);
    chk("abort_o1", o1, '0);
    i3 = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    x = mkin(1, 0, 1, 1, 0, 32'h40, 32'h0, 8);
    e = model(3, x);
    chk("abort_model_old", e.data, 32'h11112222);
    issue(3, x, e);

    for (int d = 1; d <= 3; d += 2)
      for (int n = 0; n < 150; n++) begin
        x.rw = 1'($urandom()); x.mw = 1'($urandom()); x.mr = 1'($urandom());
        x.mtr = 1'($urandom()); x.mode = 2'($urandom());
        x.alu = $urandom(); x.alu[9:6] = 4'h0;
        x.rt = $urandom(); x.dest = 5'($urandom());
        e = model(d, x);
        issue(d, x, e);
      end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
